sdp_bram_be_clr: RTL
====================

Name: sdp_bram_be_clr

Overview:
- Parametrised simple-dual-port single-clock block RAM; successor to the team's basic SDP BRAM wrapper.
- Adds:
  - per-byte write enables;
  - selectable read latency (1 or 2) with an output valid tracker;
  - a hardware clear sequencer that sweeps the array to zero after reset or on request.
- Used for predictor tables, tag arrays and any BRAM that needs a known-zero state without an init file.

Parameters:
- RAM_WIDTH, 64, data width in bits; must be a multiple of COL_WIDTH.
- COL_WIDTH, 8, bits per write-enable column; NB_COL = RAM_WIDTH/COL_WIDTH.
- RAM_DEPTH, 512, number of entries, >= 2, need not be a power of two; ADDR_W = clog2(RAM_DEPTH).
- READ_LATENCY, 2, either 1 (array register only) or 2 (array register + output register).
- CLEAR_ON_RESET, 1, 1 = start a clear sweep automatically when rstb deasserts.

Ports:
- clka  in  1  clock.
- rstb  in  1  asynchronous active-high reset; resets control and output registers, not array contents.
- addra  in  ADDR_W  write address.
- dina  in  RAM_WIDTH  write data.
- wea  in  NB_COL  per-column write enable.
- addrb  in  ADDR_W  read address.
- enb  in  1  read enable.
- regceb  in  1  output register enable; used only when READ_LATENCY=2.
- clr_req  in  1  one-cycle pulse requesting a full-array clear.
- doutb  out  RAM_WIDTH  read data.
- doutb_valid  out  1  doutb holds data from an accepted read.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset values: doutb = 0, doutb_valid = 0, all pipeline registers 0, clear counter 0.
  - FSM resets to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
  - busy is a registered output equal to (state==CLEAR): 1 out of reset when CLEAR_ON_RESET=1, else 0.
- FSM states IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1.
  - In CLEAR, each cycle writes zero to entry clr_cnt, then clr_cnt++.
  - When clr_cnt==RAM_DEPTH-1 is written: clr_cnt <= 0 and state goes to IDLE.
  - A sweep lasts exactly RAM_DEPTH cycles.
- While busy:
  - wea is ignored (user writes dropped);
  - enb is ignored (no read accepted, no valid generated);
  - clr_req is ignored.
- Write: on a clka edge with busy=0, each column c with wea[c]=1 stores dina[c*COL_WIDTH +: COL_WIDTH] at addra. Columns with wea[c]=0 are unchanged.
- Read stage 1, on a clka edge with enb=1 and busy=0:
  - ram_data <= array[addrb];
  - v1 <= 1.
  - If enb=0 or busy=1: v1 <= 0 and ram_data holds.
- READ_LATENCY=1: doutb = ram_data; doutb_valid = v1. Latency is 1 cycle.
- READ_LATENCY=2, when regceb=1: doutb <= ram_data and doutb_valid <= v1.
  - When regceb=0: doutb and doutb_valid hold.
  - Latency is 2 cycles with regceb held high.
- Out-of-range addresses (>= RAM_DEPTH, possible for non-power-of-two depths):
  - writes are dropped;
  - reads return all-zero data with valid asserted.
- Read/write collision (same addr, same cycle): behaviour is set by the optional feature below.
- rstb asserted mid-sweep: counter returns to 0.
  - On release, the sweep restarts from entry 0 if CLEAR_ON_RESET=1.
  - If CLEAR_ON_RESET=0, the array is left partially cleared and the FSM is in IDLE.
- rstb asserted mid-read: in-flight valids are lost; array contents are retained.

Optional Feature:
- Macro SDP_BRAM_WRITE_FIRST_EN.
- Defined: a read colliding with a same-cycle write returns write-first data. Enabled columns come from dina; other columns come from the array. Implemented as a bypass mux registered into ram_data.
- Not defined: a colliding read returns the pre-write (read-first) contents for all columns.
- The write always commits in both cases.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, RAM_DEPTH=512:
  - busy=1 for exactly 512 cycles, then 0;
  - then reading all 512 entries gives 0 with doutb_valid=1.
- After clear, write addr 5 dina=0x1122334455667788 wea=0xFF; read addr 5, READ_LATENCY=2, regceb=1:
  - doutb=0x1122334455667788 and doutb_valid=1 exactly 2 cycles after the enb cycle.
- Write addr 5 dina=0xAAAAAAAAAAAAAAAA wea=0x0F, then read addr 5:
  - doutb=0x11223344AAAAAAAA.
- Same-cycle write addr 9 = 0xFFFF…FF (wea=0xFF) and read addr 9, where addr 9 was 0:
  - macro defined: read returns 0xFFFF…FF;
  - macro undefined: read returns 0; a following read returns 0xFFFF…FF.
- READ_LATENCY=2, issue read, drop regceb to 0 for 3 cycles:
  - doutb and doutb_valid hold their previous values;
  - new data appears on the first cycle after regceb returns to 1.
- clr_req mid-operation, then rstb pulsed at sweep cycle 100:
  - busy stays 1; writes during busy are dropped;
  - after reset release, the sweep restarts and takes a full 512 cycles.

Source files
------------

// File: rtl/sdp_bram_be_clr.sv
// Simple-dual-port single-clock BRAM with per-column write enables, 1/2-cycle read latency
// and a zero-fill clear sequencer. Define SDP_BRAM_WRITE_FIRST_EN for write-first collisions.
module sdp_bram_be_clr #(
  parameter int unsigned RAM_WIDTH      = 64,
  parameter int unsigned COL_WIDTH      = 8,
  parameter int unsigned RAM_DEPTH      = 512,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned NB_COL        = RAM_WIDTH / COL_WIDTH,
  localparam int unsigned ADDR_W        = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic [NB_COL-1:0]    wea,
  input  logic [ADDR_W-1:0]    addrb,
  input  logic                 enb,
  input  logic                 regceb,
  input  logic                 clr_req,
  output logic [RAM_WIDTH-1:0] doutb,
  output logic                 doutb_valid,
  output logic                 busy
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(RAM_DEPTH - 1);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [RAM_WIDTH-1:0] ram_data_q;
  logic                 v1_q;
  logic                 wr_in_range, rd_in_range;
  logic [RAM_WIDTH-1:0] rd_word;

  assign busy        = (state_q == CLEAR);
  assign wr_in_range = ({1'b0, addra} < DEPTH_L);
  assign rd_in_range = ({1'b0, addrb} < DEPTH_L);

  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array has no reset; the sweep owns the write port while busy.
  always_ff @(posedge clka) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_in_range) begin
      for (int unsigned c = 0; c < NB_COL; c++) begin
        if (wea[c]) mem[addra][c*COL_WIDTH +: COL_WIDTH] <= dina[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[addrb];
`ifdef SDP_BRAM_WRITE_FIRST_EN
    if (wr_in_range && rd_in_range && (addra == addrb)) begin
      for (int unsigned c = 0; c < NB_COL; c++) begin
        if (wea[c]) rd_word[c*COL_WIDTH +: COL_WIDTH] = dina[c*COL_WIDTH +: COL_WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      ram_data_q <= '0;
      v1_q       <= 1'b0;
    end else if (enb && !busy) begin
      ram_data_q <= rd_word;
      v1_q       <= 1'b1;
    end else begin
      v1_q       <= 1'b0;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign doutb       = ram_data_q;
    assign doutb_valid = v1_q;
  end else begin : g_lat2
    logic [RAM_WIDTH-1:0] dout_q;
    logic                 dvalid_q;

    always_ff @(posedge clka or posedge rstb) begin
      if (rstb) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else if (regceb) begin
        dout_q   <= ram_data_q;
        dvalid_q <= v1_q;
      end
    end

    assign doutb       = dout_q;
    assign doutb_valid = dvalid_q;
  end

endmodule
